preamble_sync_ctrl: RTL and testbench
=====================================

# preamble_sync_ctrl

Sequencing and decision controller for the receive-side preamble correlator. Gates the correlator enable, masks the correlator warm-up interval, detects the threshold crossing, searches a fixed window for the correlation peak, and declares frame timing. After lock it emits a strobe every OFDM symbol. Sits between the ADC sample stream and the RX symbol-framing / FFT input logic.

## Interface
- CW, 22: correlator output width.
- FILL, 127: valid samples ignored after arming; covers the 64-sample delay plus the 63-stage adder pipeline.
- WIN, 16: peak-search window in valid samples, counted from the first threshold crossing.
- SYM_LEN, 320: samples per OFDM symbol (256 + 64 CP).
- SEARCH_MAX, 4096: valid samples allowed in SEARCH before timeout.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle arm request; honoured only in IDLE.
- abort  in  1  forces IDLE on the next edge, from any state.
- in_valid  in  1  upstream sample valid.
- thr  in  CW  detection threshold, unsigned; sampled every cycle.
- cr_val  in  CW  correlator output, unsigned; valid in the same cycle as cr_ena.
- cr_ena  out  1  correlator enable = in_valid & (state != IDLE); decoded from registered state.
- busy  out  1  state != IDLE.
- sync_pulse  out  1  one-cycle pulse at peak declaration.
- sync_idx  out  16  sample index of the declared peak.
- peak_val  out  CW  correlation value at the declared peak.
- locked  out  1  high while in LOCK.
- sym_start  out  1  one-cycle symbol-boundary strobe.
- timeout  out  1  one-cycle pulse when SEARCH expires.

## Operation
- States: IDLE, FILL, SEARCH, PEAK, LOCK. Every counter advances only on cycles with in_valid=1.
- smp_idx: 16-bit index of valid samples since arming. Cleared on start; the first valid sample after start has index 0. Wraps from 65535 to 0.
- IDLE: start=1 -> FILL. All counters are cleared.
- FILL: ignores cr_val. After FILL valid samples -> SEARCH.
- SEARCH: on a valid sample with cr_val > thr (strict): capture pk_val = cr_val and pk_idx = smp_idx, clear the since-peak counter sp_cnt, start the window counter -> PEAK.
- SEARCH timeout: SEARCH_MAX valid samples without a crossing -> timeout pulse -> IDLE.
- PEAK: each valid sample increments sp_cnt and the window counter. If cr_val > pk_val (strict, so the earliest sample wins ties), pk_val and pk_idx are updated and sp_cnt is cleared. The crossing sample counts as window sample 1.
- PEAK exit: after the WIN-th window sample, sync_pulse=1, sync_idx=pk_idx, peak_val=pk_val -> LOCK. sp_cnt continues counting.
- LOCK: sp_cnt counts modulo SYM_LEN. On the valid sample where sp_cnt reaches SYM_LEN-1, sym_start=1 and sp_cnt returns to 0. Threshold crossings are ignored. LOCK is left only on abort or reset.
- abort has priority over every other event in the same cycle, including start, sync_pulse and sym_start; those pulses are suppressed.
- start while busy is ignored.
- Width rules: comparisons are unsigned at CW bits; sp_cnt is 9 bits and the window counter is 5 bits, sized from the parameter defaults.

## Timing
- Reset values: all outputs 0; state IDLE; sync_idx 0; peak_val 0.
- Outputs are registered, except cr_ena and busy, which are decoded from registered state.
- Latency: start -> FILL at the next edge. cr_ena is active from the cycle after start.
- sync_pulse is asserted the cycle after the edge that samples the WIN-th window sample.
- The first sym_start comes SYM_LEN valid samples after the peak sample, minus processing alignment. It is asserted in the cycle after the edge that samples the sample where sp_cnt = SYM_LEN-1.
- sync_idx and peak_val hold their values until the next start or reset.
- Async reset mid-operation: immediate return to IDLE; all pulses deasserted.

## Configuration
- Macro SYNC_SEARCH_TIMEOUT_EN.
- Defined: the SEARCH timeout behaves as described above.
- Undefined: SEARCH waits indefinitely, timeout is tied to 0, and the SEARCH counter is not synthesized.

## Test plan
- Reset, then start with continuous in_valid and cr_val=0, thr=1000 -> busy=1 and cr_ena=1 from the next cycle. With the macro defined: timeout pulse after 127+4096 valid samples, then IDLE. With the macro undefined: no timeout after 10000 samples.
- cr_val=5000 at sample 200 only, thr=1000 -> sync_pulse after sample 215, sync_idx=200, peak_val=5000, locked=1. sym_start pulses after samples 519, 839, 1159.
- Crossing at sample 200 with value 1500, peak 9000 at 207, 9000 again at 209 -> sync_idx=207, peak_val=9000 (earliest tie wins). First sym_start after sample 526.
- cr_val=60000 during FILL samples 0..126, then 0 -> no crossing is detected. FILL is masked.
- in_valid toggling 1/0 with the same scenario as the second test -> identical sync_idx; sync_pulse and sym_start occur only on valid-sample boundaries, at twice the cycle distance.
- abort asserted in the same cycle as the window-closing sample -> no sync_pulse, IDLE next cycle. rst driven low during LOCK -> all outputs 0 immediately. start asserted while locked -> ignored.

Source files
------------

// File: rtl/preamble_sync_ctrl_if.sv
// Sample-stream, threshold and decision signals of the preamble sync controller.
interface preamble_sync_ctrl_if #(
   parameter int CW = 22
);
   logic          start;
   logic          abort;
   logic          in_valid;
   logic [CW-1:0] thr;
   logic [CW-1:0] cr_val;
   logic          cr_ena;
   logic          busy;
   logic          sync_pulse;
   logic [15:0]   sync_idx;
   logic [CW-1:0] peak_val;
   logic          locked;
   logic          sym_start;
   logic          timeout;

   modport master (
      output start, abort, in_valid, thr, cr_val,
      input  cr_ena, busy, sync_pulse, sync_idx, peak_val, locked, sym_start, timeout
   );

   modport slave (
      input  start, abort, in_valid, thr, cr_val,
      output cr_ena, busy, sync_pulse, sync_idx, peak_val, locked, sym_start, timeout
   );
endinterface

// File: rtl/preamble_sync_ctrl.sv
// Preamble correlator sequencer: warm-up mask, threshold crossing, peak window, symbol strobes.
// Optional SEARCH timeout enabled by defining SYNC_SEARCH_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | disarmed, counters held clear, waiting for start
// S_FILL   | correlator warm-up, cr_val ignored
// S_SEARCH | waiting for cr_val > thr
// S_PEAK   | searching the window for the maximum
// S_LOCK   | frame timing declared, one strobe per symbol
module preamble_sync_ctrl #(
   parameter int CW         = 22,
   parameter int FILL       = 127,
   parameter int WIN        = 16,
   parameter int SYM_LEN    = 320,
   parameter int SEARCH_MAX = 4096
) (
   input logic                clk,
   input logic                rst,
   preamble_sync_ctrl_if.slave bus
);
   localparam int FILL_W = $clog2(FILL);
   localparam int WIN_W  = $clog2(WIN + 1);
   localparam int SP_W   = $clog2(SYM_LEN);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_SEARCH, S_PEAK, S_LOCK} state_t;

   state_t          state, state_n;
   logic [15:0]     smp_idx, smp_n;
   logic [FILL_W-1:0] fill_cnt, fill_n;
   logic [WIN_W-1:0] win_cnt, win_n;
   logic [SP_W-1:0] sp_cnt, sp_n, sp_inc;
   logic [CW-1:0]   pk_val, pk_val_n, peak_val_q, peak_val_n;
   logic [15:0]     pk_idx, pk_idx_n, sync_idx_q, sync_idx_n;
   logic            sync_pulse_q, sync_pulse_n, sym_start_q, sym_start_n;
   logic            locked_q, locked_n, timeout_n;
   logic            crossing, beats;

   assign crossing = bus.cr_val > bus.thr;
   assign beats    = bus.cr_val > pk_val;
   // Modulo-SYM_LEN count: the strobe fires on the sample that lands on SYM_LEN-1.
   assign sp_inc   = (sp_cnt == SP_W'(SYM_LEN - 1)) ? '0 : sp_cnt + SP_W'(1);

`ifdef SYNC_SEARCH_TIMEOUT_EN
   localparam int SRCH_W = $clog2(SEARCH_MAX);
   logic [SRCH_W-1:0] srch_cnt, srch_n;
   logic              timeout_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         smp_idx      <= '0;
         fill_cnt     <= '0;
         win_cnt      <= '0;
         sp_cnt       <= '0;
         pk_val       <= '0;
         pk_idx       <= '0;
         peak_val_q   <= '0;
         sync_idx_q   <= '0;
         sync_pulse_q <= 1'b0;
         sym_start_q  <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state        <= state_n;
         smp_idx      <= smp_n;
         fill_cnt     <= fill_n;
         win_cnt      <= win_n;
         sp_cnt       <= sp_n;
         pk_val       <= pk_val_n;
         pk_idx       <= pk_idx_n;
         peak_val_q   <= peak_val_n;
         sync_idx_q   <= sync_idx_n;
         sync_pulse_q <= sync_pulse_n;
         sym_start_q  <= sym_start_n;
         locked_q     <= locked_n;
      end
   end

`ifdef SYNC_SEARCH_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         srch_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         srch_cnt  <= srch_n;
         timeout_q <= timeout_n;
      end
   end
`endif

   always_comb begin
      state_n      = state;
      smp_n        = smp_idx;
      fill_n       = fill_cnt;
      win_n        = win_cnt;
      sp_n         = sp_cnt;
      pk_val_n     = pk_val;
      pk_idx_n     = pk_idx;
      sync_idx_n   = sync_idx_q;
      peak_val_n   = peak_val_q;
      sync_pulse_n = 1'b0;
      sym_start_n  = 1'b0;
      timeout_n    = 1'b0;
`ifdef SYNC_SEARCH_TIMEOUT_EN
      srch_n       = srch_cnt;
`endif
      case (state)
         S_IDLE: begin
            smp_n  = '0;
            fill_n = FILL_W'(FILL - 1);
            win_n  = '0;
            sp_n   = '0;
            if (bus.start) begin
               state_n    = S_FILL;
               pk_val_n   = '0;
               pk_idx_n   = '0;
               sync_idx_n = '0;
               peak_val_n = '0;
            end
         end
         S_FILL: if (bus.in_valid) begin
            smp_n = smp_idx + 16'd1;
            if (fill_cnt == '0) begin
               state_n = S_SEARCH;
`ifdef SYNC_SEARCH_TIMEOUT_EN
               srch_n  = SRCH_W'(SEARCH_MAX - 1);
`endif
            end else begin
               fill_n = fill_cnt - FILL_W'(1);
            end
         end
         S_SEARCH: if (bus.in_valid) begin
            smp_n = smp_idx + 16'd1;
            if (crossing) begin
               state_n  = S_PEAK;
               pk_val_n = bus.cr_val;
               pk_idx_n = smp_idx;
               sp_n     = '0;
               win_n    = WIN_W'(WIN - 1);
            end
`ifdef SYNC_SEARCH_TIMEOUT_EN
            else if (srch_cnt == '0) begin
               state_n   = S_IDLE;
               timeout_n = 1'b1;
            end else begin
               srch_n = srch_cnt - SRCH_W'(1);
            end
`endif
         end
         S_PEAK: if (bus.in_valid) begin
            smp_n = smp_idx + 16'd1;
            if (beats) begin
               pk_val_n = bus.cr_val;
               pk_idx_n = smp_idx;
               sp_n     = '0;
            end else begin
               sp_n = sp_inc;
            end
            if (win_cnt == WIN_W'(1)) begin
               state_n      = S_LOCK;
               sync_pulse_n = 1'b1;
               sync_idx_n   = pk_idx_n;
               peak_val_n   = pk_val_n;
            end else begin
               win_n = win_cnt - WIN_W'(1);
            end
         end
         S_LOCK: if (bus.in_valid) begin
            smp_n       = smp_idx + 16'd1;
            sp_n        = sp_inc;
            sym_start_n = (sp_inc == SP_W'(SYM_LEN - 1));
         end
         default: state_n = S_IDLE;
      endcase
      // abort wins over everything, and the published peak result is left untouched
      if (bus.abort) begin
         state_n      = S_IDLE;
         sync_pulse_n = 1'b0;
         sym_start_n  = 1'b0;
         timeout_n    = 1'b0;
         sync_idx_n   = sync_idx_q;
         peak_val_n   = peak_val_q;
      end
      locked_n = (state_n == S_LOCK);
   end

   assign bus.busy       = (state != S_IDLE);
   assign bus.cr_ena     = bus.in_valid & (state != S_IDLE);
   assign bus.sync_pulse = sync_pulse_q;
   assign bus.sync_idx   = sync_idx_q;
   assign bus.peak_val   = peak_val_q;
   assign bus.locked     = locked_q;
   assign bus.sym_start  = sym_start_q;
`ifdef SYNC_SEARCH_TIMEOUT_EN
   assign bus.timeout    = timeout_q;
`else
   assign bus.timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_preamble_sync_ctrl.sv
// Self-checking bench for preamble_sync_ctrl: expected events queued with stimulus, popped on DUT pulses.
module tb_preamble_sync_ctrl;
   localparam int CW = 22;
   localparam int K_SYNC = 1, K_SYM = 2, K_TMO = 3;

   typedef struct {
      int kind;
      int smp;
      int idx;
      int val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   next_smp = 0;
   int   last_smp = -1;
   logic last_valid = 1'b0;
   exp_t sb[$];
   exp_t e;
   int   kind;

   preamble_sync_ctrl_if #(.CW(CW)) bus ();

   preamble_sync_ctrl #(
      .CW(CW), .FILL(127), .WIN(16), .SYM_LEN(320), .SEARCH_MAX(4096)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // scoreboard: every DUT pulse must match the next expected event
   always @(negedge clk) begin
      if (rst && (bus.sync_pulse || bus.sym_start || bus.timeout)) begin
         kind = bus.sync_pulse ? K_SYNC : (bus.sym_start ? K_SYM : K_TMO);
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d after sample %0d, required no event", kind, last_smp);
         end else begin
            e = sb.pop_front();
            if (kind !== e.kind || last_smp !== e.smp || last_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL event_timing: got kind %0d after sample %0d (valid edge %b), required kind %0d after sample %0d",
                        kind, last_smp, last_valid, e.kind, e.smp);
            end
            if (e.kind == K_SYNC) begin
               n_checks++;
               if (bus.sync_idx !== 16'(e.idx) || bus.peak_val !== CW'(e.val) || bus.locked !== 1'b1) begin
                  n_fail++;
                  $display("FAIL sync_values: got idx %0d val %0d locked %b, required idx %0d val %0d locked 1",
                           bus.sync_idx, bus.peak_val, bus.locked, e.idx, e.val);
               end
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [CW-1:0] c);
      bus.in_valid = v;
      bus.cr_val   = c;
      @(posedge clk);
      last_valid = v;
      if (v) begin
         last_smp = next_smp;
         next_smp++;
      end
      @(negedge clk);
   endtask

   task automatic do_start();
      sb.delete();
      bus.start    = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      next_smp  = 0;
   endtask

   task automatic do_abort();
      bus.abort    = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b0;
   endtask

   task automatic push(input int k, input int s, input int i, input int v);
      exp_t x;
      x.kind = k; x.smp = s; x.idx = i; x.val = v;
      sb.push_back(x);
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0;
      bus.thr = CW'(1000); bus.cr_val = '0;
      rst = 1'b0;
      #12;
      n_checks++;
      if ({bus.busy, bus.cr_ena, bus.sync_pulse, bus.locked, bus.sym_start, bus.timeout} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b, required 000000",
                  {bus.busy, bus.cr_ena, bus.sync_pulse, bus.locked, bus.sym_start, bus.timeout});
      end
      n_checks++;
      if (bus.sync_idx !== 16'd0 || bus.peak_val !== '0) begin
         n_fail++;
         $display("FAIL reset_values: got idx %0d val %0d, required 0 0", bus.sync_idx, bus.peak_val);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_timeout();
      do_start();
      bus.in_valid = 1'b1;
      bus.cr_val   = '0;
      #1;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.cr_ena !== 1'b1) begin
         n_fail++;
         $display("FAIL arm_busy_ena: got busy %b cr_ena %b, required 1 1", bus.busy, bus.cr_ena);
      end
`ifdef SYNC_SEARCH_TIMEOUT_EN
      push(K_TMO, 127 + 4096 - 1, 0, 0);
      for (int s = 0; s < 127 + 4096; s++) drive(1'b1, '0);
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_idle: got busy %b, required 0", bus.busy);
      end
`else
      for (int s = 0; s < 10000; s++) drive(1'b1, '0);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL no_timeout_busy: got busy %b, required 1", bus.busy);
      end
      do_abort();
`endif
      n_checks++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL timeout_events: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_single_peak();
      do_start();
      push(K_SYNC, 215, 200, 5000);
      push(K_SYM, 519, 0, 0);
      push(K_SYM, 839, 0, 0);
      push(K_SYM, 1159, 0, 0);
      for (int s = 0; s <= 1200; s++) drive(1'b1, (s == 200) ? CW'(5000) : '0);
      n_checks++;
      if (bus.locked !== 1'b1 || bus.sync_idx !== 16'd200 || bus.peak_val !== CW'(5000) || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL single_peak_lock: got locked %b idx %0d val %0d pending %0d, required 1 200 5000 0",
                  bus.locked, bus.sync_idx, bus.peak_val, sb.size());
      end
      do_abort();
      n_checks++;
      if (bus.locked !== 1'b0 || bus.busy !== 1'b0 || bus.sync_idx !== 16'd200) begin
         n_fail++;
         $display("FAIL abort_hold: got locked %b busy %b idx %0d, required 0 0 200",
                  bus.locked, bus.busy, bus.sync_idx);
      end
   endtask

   task automatic test_tie_peak();
      logic [CW-1:0] c;
      do_start();
      push(K_SYNC, 215, 207, 9000);
      push(K_SYM, 526, 0, 0);
      for (int s = 0; s <= 600; s++) begin
         c = '0;
         if (s == 200) c = CW'(1500);
         if (s == 207 || s == 209) c = CW'(9000);
         drive(1'b1, c);
      end
      n_checks++;
      if (bus.sync_idx !== 16'd207 || bus.peak_val !== CW'(9000) || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL tie_peak: got idx %0d val %0d pending %0d, required 207 9000 0",
                  bus.sync_idx, bus.peak_val, sb.size());
      end
      do_abort();
   endtask

   task automatic test_fill_mask();
      do_start();
      for (int s = 0; s < 400; s++) drive(1'b1, (s < 127) ? CW'(60000) : '0);
      n_checks++;
      if (bus.locked !== 1'b0 || bus.busy !== 1'b1 || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL fill_mask: got locked %b busy %b, required 0 1", bus.locked, bus.busy);
      end
      do_abort();
   endtask

   task automatic test_gapped();
      do_start();
      push(K_SYNC, 215, 200, 5000);
      push(K_SYM, 519, 0, 0);
      push(K_SYM, 839, 0, 0);
      for (int s = 0; s <= 900; s++) begin
         drive(1'b1, (s == 200) ? CW'(5000) : '0);
         drive(1'b0, CW'(60000));
      end
      n_checks++;
      if (bus.sync_idx !== 16'd200 || bus.locked !== 1'b1 || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL gapped: got idx %0d locked %b pending %0d, required 200 1 0",
                  bus.sync_idx, bus.locked, sb.size());
      end
      do_abort();
   endtask

   task automatic test_abort_window();
      do_start();
      for (int s = 0; s < 215; s++) drive(1'b1, (s == 200) ? CW'(5000) : '0);
      bus.abort = 1'b1;
      drive(1'b1, '0);
      bus.abort = 1'b0;
      n_checks++;
      if (bus.sync_pulse !== 1'b0 || bus.busy !== 1'b0 || bus.locked !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_window: got pulse %b busy %b locked %b, required 0 0 0",
                  bus.sync_pulse, bus.busy, bus.locked);
      end
   endtask

   task automatic test_reset_lock();
      do_start();
      push(K_SYNC, 215, 200, 5000);
      for (int s = 0; s <= 300; s++) drive(1'b1, (s == 200) ? CW'(5000) : '0);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.sync_pulse, bus.locked, bus.sym_start, bus.timeout} !== 5'b0 ||
          bus.sync_idx !== 16'd0 || bus.peak_val !== '0) begin
         n_fail++;
         $display("FAIL reset_in_lock: got busy %b locked %b idx %0d val %0d, required 0 0 0 0",
                  bus.busy, bus.locked, bus.sync_idx, bus.peak_val);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_start_locked();
      logic [CW-1:0] c;
      do_start();
      push(K_SYNC, 215, 200, 5000);
      push(K_SYM, 519, 0, 0);
      for (int s = 0; s <= 600; s++) begin
         c = '0;
         if (s == 200) c = CW'(5000);
         if (s == 300) c = CW'(9000);
         bus.start = (s == 250);
         drive(1'b1, c);
      end
      bus.start = 1'b0;
      n_checks++;
      if (bus.locked !== 1'b1 || bus.sync_idx !== 16'd200 || bus.peak_val !== CW'(5000) || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL start_in_lock: got locked %b idx %0d val %0d pending %0d, required 1 200 5000 0",
                  bus.locked, bus.sync_idx, bus.peak_val, sb.size());
      end
      do_abort();
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_single_peak();
      test_tie_peak();
      test_fill_mask();
      test_gapped();
      test_abort_window();
      test_reset_lock();
      test_start_locked();
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
